// File: rtl/tvip_reset_sequencer.sv
// Multi-channel reset generator: power-on hold after i_reset, run-time requested
// holds with a channel mask, and ascending-index release with a fixed inter-channel gap.
module tvip_reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_WIDTH = 16,
  parameter int RELEASE_GAP = 2,
  parameter int POR_CYCLES  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [COUNT_WIDTH-1:0] i_duration,
  input  logic [CHANNELS-1:0]    i_channel_mask,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CHANNELS-1:0]    o_reset,
  output logic [CHANNELS-1:0]    o_reset_n
);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  localparam logic [CHANNELS-1:0]    ONE_C = CHANNELS'(1);
  localparam logic [COUNT_WIDTH-1:0] ONE_W = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] GAP_W = COUNT_WIDTH'(RELEASE_GAP);
  localparam logic [COUNT_WIDTH-1:0] POR_W = COUNT_WIDTH'(POR_CYCLES);

  state_t                 state_reg, state_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;
  logic [CHANNELS-1:0]    pend_reg, pend_next;
  logic [CHANNELS-1:0]    reset_reg, reset_next;
  logic                   done_reg, done_next;
  logic                   busy_reg, busy_next;
  logic [CHANNELS-1:0]    drop_mask;

  // With no gap every pending channel goes at once; otherwise only the lowest pending index.
  always_comb begin
    if (RELEASE_GAP == 0) drop_mask = pend_reg;
    else                  drop_mask = pend_reg & (~pend_reg + ONE_C);
  end

  // count_reg is the hold length in HOLD and the inter-release gap in RELEASE;
  // an event fires on the cycle it reads 1, so the full 2^COUNT_WIDTH-1 range is usable.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    pend_next  = pend_reg;
    reset_next = reset_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          if (i_channel_mask == '0) begin
            state_next = RELEASE;
            pend_next  = '0;
            done_next  = 1'b1;
          end else begin
            state_next = HOLD;
            pend_next  = i_channel_mask;
            reset_next = reset_reg | i_channel_mask;
            count_next = (i_duration == '0) ? ONE_W : i_duration;
          end
        end
      end
      HOLD, RELEASE: begin
        if (pend_reg == '0) begin
          state_next = IDLE;
        end else if (count_reg == ONE_W) begin
          state_next = RELEASE;
          reset_next = reset_reg & ~drop_mask;
          pend_next  = pend_reg & ~drop_mask;
          count_next = GAP_W;
          done_next  = ((pend_reg & ~drop_mask) == '0);
        end else begin
          count_next = count_reg - ONE_W;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= HOLD;
      count_reg <= POR_W;
      pend_reg  <= '1;
      reset_reg <= '1;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      pend_reg  <= pend_next;
      reset_reg <= reset_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  assign o_busy  = busy_reg;
  assign o_done  = done_reg;
  assign o_reset = reset_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_reset_n
      assign o_reset_n[gi] = ~reset_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_tvip_reset_sequencer.sv
// Bench for tvip_reset_sequencer: a gap-2 and a gap-0 instance share stimulus and are
// compared every cycle against a release-schedule model (drop cycle = t0 + D + 1 + rank*gap).
module tb_tvip_reset_sequencer;

  localparam int POR = 8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dur;
  logic [3:0]  mask;

  logic [3:0] o_rst  [2];
  logic [3:0] o_rstn [2];
  logic       o_bsy  [2];
  logic       o_dn   [2];

  tvip_reset_sequencer #(.CHANNELS(4), .COUNT_WIDTH(16), .RELEASE_GAP(2), .POR_CYCLES(POR)) dut_gap2 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_duration(dur), .i_channel_mask(mask),
    .o_busy(o_bsy[0]), .o_done(o_dn[0]), .o_reset(o_rst[0]), .o_reset_n(o_rstn[0]));

  tvip_reset_sequencer #(.CHANNELS(4), .COUNT_WIDTH(16), .RELEASE_GAP(0), .POR_CYCLES(POR)) dut_gap0 (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_duration(dur), .i_channel_mask(mask),
    .o_busy(o_bsy[1]), .o_done(o_dn[1]), .o_reset(o_rst[1]), .o_reset_n(o_rstn[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model: one schedule per instance.
  logic [3:0] base_m [2];
  logic [3:0] m_m    [2];
  longint     t0_m   [2];
  longint     end_t  [2];
  longint     drop_t [2][4];
  logic [3:0] exp_r  [2];
  logic       exp_b  [2];
  logic       exp_d  [2];

  task automatic schedule(input int k, input longint t0, input longint d, input logic [3:0] m);
    int r;
    int g;
    r = 0;
    g = (k == 0) ? 2 : 0;
    base_m[k] = exp_r[k];
    m_m[k]    = m;
    t0_m[k]   = t0;
    end_t[k]  = t0 + 1;
    for (int i = 0; i < 4; i++) begin
      drop_t[k][i] = 0;
      if (m[i]) begin
        drop_t[k][i] = t0 + d + 1 + longint'(r * g);
        end_t[k]     = drop_t[k][i];
        r++;
      end
    end
  endtask

  // Consume this cycle's inputs into the model, advance one clock, compute expectations.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (rst) schedule(k, cyc, POR, 4'hF);
      else if (start && !exp_b[k]) schedule(k, cyc, (dur == 16'd0) ? 1 : longint'(dur), mask);
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++)
        exp_r[k][i] = m_m[k][i] ? (cyc < drop_t[k][i]) : base_m[k][i];
      exp_b[k] = (cyc > t0_m[k]) && (cyc <= end_t[k]);
      exp_d[k] = (cyc == end_t[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL reset_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
      n_checks++;
      if (o_rst[0] !== 4'hF || o_bsy[0] !== 1'b1 || o_dn[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc=%0d got rst=%h busy=%b done=%b exp rst=f busy=1 done=0",
                 cyc, o_rst[0], o_bsy[0], o_dn[0]);
      end
    end
    rst = 1'b0;
    $display("txn reset: 3 cycles of i_reset, released at cycle %0d", cyc);
  endtask

  task automatic test_power_on();
    longint last_rst;
    longint rel;
    logic [3:0] exp_po;
    last_rst = cyc - 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      rel = cyc - last_rst;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL power_on_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
      exp_po = (rel <= 8) ? 4'hF : (rel <= 10) ? 4'hE : (rel <= 12) ? 4'hC : (rel <= 14) ? 4'h8 : 4'h0;
      n_checks++;
      if (o_rst[0] !== exp_po || o_dn[0] !== (rel == 15) || o_bsy[0] !== (rel <= 15)) begin
        n_fail++;
        $display("FAIL power_on_timing rel=%0d got rst=%h done=%b busy=%b exp rst=%h done=%b busy=%b",
                 rel, o_rst[0], o_dn[0], o_bsy[0], exp_po, rel == 15, rel <= 15);
      end
      n_checks++;
      if (o_rst[1] !== ((rel <= 8) ? 4'hF : 4'h0) || o_dn[1] !== (rel == 9)) begin
        n_fail++;
        $display("FAIL power_on_gap0 rel=%0d got rst=%h done=%b", rel, o_rst[1], o_dn[1]);
      end
    end
  endtask

  task automatic test_masked();
    longint t0;
    longint rel;
    logic [3:0] exp_m;
    t0 = cyc;
    start = 1'b1; mask = 4'b1010; dur = 16'd5;
    $display("txn masked: cycle %0d mask=1010 D=5", cyc);
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) start = 1'b0;
      rel = cyc - t0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL masked_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
      exp_m = {rel <= 7, 1'b0, rel <= 5, 1'b0};
      n_checks++;
      if (o_rst[0] !== exp_m || o_dn[0] !== (rel == 8)) begin
        n_fail++;
        $display("FAIL masked_timing rel=%0d got rst=%h done=%b exp rst=%h done=%b",
                 rel, o_rst[0], o_dn[0], exp_m, rel == 8);
      end
    end
  endtask

  task automatic test_duration();
    longint t0;
    longint rel;
    for (int pass = 0; pass < 2; pass++) begin
      t0 = cyc;
      start = 1'b1; mask = 4'b0001; dur = 16'(pass);
      $display("txn duration: cycle %0d mask=0001 D=%0d", cyc, pass);
      for (int n = 1; n <= 4; n++) begin
        tick();
        if (n == 1) start = 1'b0;
        rel = cyc - t0;
        for (int k = 0; k < 2; k++) begin
          n_checks++;
          if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
            n_fail++;
            $display("FAIL duration_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                     cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
          end
        end
        n_checks++;
        if (o_rst[0] !== {3'b000, rel <= 1} || o_dn[0] !== (rel == 2)) begin
          n_fail++;
          $display("FAIL duration_short D=%0d rel=%0d got rst=%h done=%b exp rst=%h done=%b",
                   pass, rel, o_rst[0], o_dn[0], {3'b000, rel <= 1}, rel == 2);
        end
      end
    end
    t0 = cyc;
    start = 1'b1; mask = 4'b0100; dur = 16'hFFFF;
    $display("txn duration: cycle %0d mask=0100 D=65535", cyc);
    for (int n = 1; n <= 65538; n++) begin
      tick();
      if (n == 1) start = 1'b0;
      rel = cyc - t0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL duration_max_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
      if (rel == 65535 || rel == 65536) begin
        n_checks++;
        if (o_rst[0] !== ((rel == 65535) ? 4'b0100 : 4'b0000) || o_dn[0] !== (rel == 65536)) begin
          n_fail++;
          $display("FAIL duration_max rel=%0d got rst=%h done=%b", rel, o_rst[0], o_dn[0]);
        end
      end
    end
  endtask

  task automatic test_busy_start();
    longint t0;
    longint t1;
    longint rel;
    bit     second;
    t0 = cyc;
    t1 = 0;
    second = 1'b0;
    start = 1'b1; mask = 4'hF; dur = 16'd6;
    $display("txn busy_start: cycle %0d mask=1111 D=6", cyc);
    for (int n = 1; n <= 40; n++) begin
      tick();
      rel = cyc - t0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL busy_start_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
      if (rel == 7) begin
        n_checks++;
        if (o_rst[0] !== 4'b1110) begin
          n_fail++;
          $display("FAIL busy_start_ignored rel=7 got rst=%h exp rst=e", o_rst[0]);
        end
      end
      if (second && cyc > t1 && cyc <= t1 + 4) begin
        n_checks++;
        if (o_rst[0] !== ((cyc <= t1 + 2) ? 4'b0100 : 4'b0000) || o_dn[0] !== (cyc == t1 + 3)) begin
          n_fail++;
          $display("FAIL busy_start_restart rel=%0d got rst=%h done=%b", cyc - t1, o_rst[0], o_dn[0]);
        end
      end
      start = 1'b0;
      if (n == 3) begin
        start = 1'b1; mask = 4'b0001; dur = 16'd1;
        $display("txn busy_start: cycle %0d start while busy (expect ignored)", cyc);
      end else if (!second && n > 3 && !exp_b[0]) begin
        second = 1'b1;
        t1 = cyc;
        start = 1'b1; mask = 4'b0100; dur = 16'd2;
        $display("txn busy_start: cycle %0d first idle cycle, mask=0100 D=2", cyc);
      end
    end
    n_checks++;
    if (!second) begin
      n_fail++;
      $display("FAIL busy_start_idle_timeout got busy=%b exp busy=0 within 40 cycles", o_bsy[0]);
    end
  endtask

  task automatic test_abort();
    longint t0;
    longint rel_p;
    t0 = cyc;
    start = 1'b1; mask = 4'hF; dur = 16'd3;
    $display("txn abort: cycle %0d mask=1111 D=3, i_reset at cycle %0d", cyc, cyc + 5);
    for (int n = 1; n <= 30; n++) begin
      tick();
      rel_p = cyc - (t0 + 5);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL abort_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
      if (n >= 6) begin
        n_checks++;
        if (o_dn[0] !== (rel_p == 15) || (rel_p <= 8 && o_rst[0] !== 4'hF)) begin
          n_fail++;
          $display("FAIL abort_por rel=%0d got rst=%h done=%b", rel_p, o_rst[0], o_dn[0]);
        end
      end
      start = 1'b0;
      rst = (n == 5);
    end
  endtask

  task automatic test_mask0();
    longint t0;
    t0 = cyc;
    start = 1'b1; mask = 4'b0000; dur = 16'd7;
    $display("txn mask0: cycle %0d mask=0000 D=7", cyc);
    for (int n = 1; n <= 4; n++) begin
      tick();
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL mask0_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
      n_checks++;
      if (o_rst[0] !== 4'h0 || o_bsy[0] !== (n == 1) || o_dn[0] !== (n == 1)) begin
        n_fail++;
        $display("FAIL mask0 rel=%0d got rst=%h busy=%b done=%b exp rst=0 busy=%b done=%b",
                 cyc - t0, o_rst[0], o_bsy[0], o_dn[0], n == 1, n == 1);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      mask  = 4'($urandom);
      dur   = 16'($urandom_range(0, 7));
      if (start && !rst && !exp_b[0])
        $display("txn random: cycle %0d mask=%b D=%0d", cyc, mask, dur);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_rst[k], o_rstn[k], o_bsy[k], o_dn[k]} !== {exp_r[k], ~exp_r[k], exp_b[k], exp_d[k]}) begin
          n_fail++;
          $display("FAIL random_model cyc=%0d inst=%0d got rst=%h rstn=%h busy=%b done=%b exp rst=%h busy=%b done=%b",
                   cyc, k, o_rst[k], o_rstn[k], o_bsy[k], o_dn[k], exp_r[k], exp_b[k], exp_d[k]);
        end
      end
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dur = 16'd0; mask = 4'h0;
    for (int k = 0; k < 2; k++) begin
      exp_r[k] = 4'hF; exp_b[k] = 1'b1; exp_d[k] = 1'b0;
      base_m[k] = 4'hF; m_m[k] = 4'hF; t0_m[k] = 0; end_t[k] = 0;
      for (int i = 0; i < 4; i++) drop_t[k][i] = 0;
    end
    test_reset();
    test_power_on();
    test_masked();
    test_duration();
    test_busy_start();
    test_abort();
    test_mask0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
